// File: rtl/ov5640_wr_ctrl.sv
// ov5640_wr_ctrl: buffers camera pixels in a FIFO and writes them to SDRAM in fixed-length bursts,
// walking a frame buffer and resynchronising to the frame start pulse.
module ov5640_wr_ctrl #(
    parameter int          H_PIXEL    = 1024,
    parameter int          V_PIXEL    = 768,
    parameter int          BURST_LEN  = 256,
    parameter int          FIFO_DEPTH = 512,
    parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [15:0] m_data,
    input  logic        m_wr_en,
    input  logic        frame_sync,
    output logic        wr_req,
    input  logic        wr_ack,
    input  logic        wr_en,
    output logic [15:0] wr_data,
    output logic [23:0] wr_addr,
    output logic        frame_done,
    output logic        ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [LW-1:0] BL        = LW'(BURST_LEN);
    localparam logic [LW-1:0] FULL_L    = LW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [23:0]   STEP      = 24'(BURST_LEN);
    localparam logic [23:0]   END_ADDR  = BASE_ADDR + 24'(H_PIXEL * V_PIXEL);

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    state_t        state, state_nxt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [BW-1:0] beat;
    logic          sync_pend;
    logic          full, push, pop, apply, last, wrap;
    logic [23:0]   next_addr;

    assign full      = level == FULL_L;
    assign push      = m_wr_en && !full && !sync_pend;
    assign pop       = state == BURST && wr_en;
    assign apply     = state == IDLE && sync_pend;
    assign last      = pop && beat == LAST_BEAT;
    assign next_addr = wr_addr + STEP;
    assign wrap      = next_addr == END_ADDR;
    assign wr_req    = state == REQ;
    // Empty FIFO presents zero so the head word is defined without resetting the RAM.
    assign wr_data   = level == '0 ? 16'h0000 : mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!sync_pend && !frame_sync && level >= BL) state_nxt = REQ;
            REQ:     if (wr_ack) state_nxt = BURST;
            BURST:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk)
        if (push) mem[wr_ptr] <= m_data;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            beat       <= '0;
            sync_pend  <= 1'b0;
            wr_addr    <= BASE_ADDR;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= last && wrap;
            sync_pend  <= frame_sync || (sync_pend && !apply);
            beat       <= last ? '0 : pop ? beat + 1'b1 : beat;
            if (apply) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                wr_addr <= BASE_ADDR;
                ovf     <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr == LAST_PTR ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr == LAST_PTR ? '0 : rd_ptr + 1'b1;
                level <= level + LW'(push) - LW'(pop);
                if (m_wr_en && full && !sync_pend) ovf <= 1'b1;
                if (last) wr_addr <= wrap ? BASE_ADDR : next_addr;
            end
        end
    end
endmodule
